// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded controls and operands for EX,
// detects load-use hazards, inserts bubbles and counts them (saturating).
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_Branch,
  input  logic             id_MemRead,
  input  logic             id_MemtoReg,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc,
  input  logic             id_RegWrite,
  input  logic [1:0]       id_ALUOp,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_MemtoReg,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic             ex_RegWrite,
  output logic [1:0]       ex_ALUOp,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [3:0]       ex_funct,
  output logic [CNT_W-1:0] stall_count
);

  // Packed controls: {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp}
  logic [7:0] ctrl_p0;
  logic [7:0] ctrl_p1;
  logic       vld_p1;
  logic       uses_rs2;
  logic       hazard;

  // Counter holds at all ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (&v) ? v : v + one;
  endfunction

  assign ctrl_p0 = {id_Branch, id_MemRead, id_MemtoReg, id_MemWrite,
                    id_ALUSrc, id_RegWrite, id_ALUOp};

  // rs2 is a real source for R-type, branches and stores (ALUSrc=0 or store)
  assign uses_rs2 = ~id_ALUSrc | id_MemWrite;

  // A load in EX whose destination ID reads must be separated by one bubble;
  // x0 is never a real dependency.
  assign hazard = id_valid & vld_p1 & ctrl_p1[6] & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));

  // A flushed ID instruction is dead, so it never needs to wait
  assign stall = ~reset & ((hazard & ~flush) | hold);

  // ---- ID -> EX boundary ----

  // Control path and bubble counter: flush > hold > hazard bubble > load
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      stall_count <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (!hold) begin
      if (hazard) begin
        vld_p1      <= 1'b0;
        ctrl_p1     <= '0;
        stall_count <= sat_inc(stall_count);
      end else begin
        vld_p1  <= id_valid;
        ctrl_p1 <= id_valid ? ctrl_p0 : 8'd0;
      end
    end
  end

  // Operand path: loads whenever not frozen; contents are meaningless in a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
    end else if (flush || !hold) begin
      ex_pc     <= id_pc;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct  <= id_funct;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_Branch   = ctrl_p1[7];
  assign ex_MemRead  = ctrl_p1[6];
  assign ex_MemtoReg = ctrl_p1[5];
  assign ex_MemWrite = ctrl_p1[4];
  assign ex_ALUSrc   = ctrl_p1[3];
  assign ex_RegWrite = ctrl_p1[2];
  assign ex_ALUOp    = ctrl_p1[1:0];

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each cycle's
// EX contents; a second instance with a 4-bit counter exercises saturation.
module tb_id_ex_stage;

  localparam logic [7:0] OP_R    = 8'b0000_0110;
  localparam logic [7:0] OP_LW   = 8'b0110_1100;
  localparam logic [7:0] OP_SW   = 8'b0001_1000;
  localparam logic [7:0] OP_ADDI = 8'b0000_1110;
  localparam logic [7:0] OP_BEQ  = 8'b1000_0001;

  typedef struct packed {
    logic        valid;
    logic [7:0]  c;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        cmp;
  } exp_t;

  logic clk = 1'b0;
  logic reset, id_valid, flush, hold;
  logic [7:0]  id_c;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;

  logic stall, ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]  ex_ALUOp;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [15:0] stall_count;

  logic stall_s, ex_valid_s, ex_Branch_s, ex_MemRead_s, ex_MemtoReg_s, ex_MemWrite_s, ex_ALUSrc_s, ex_RegWrite_s;
  logic [1:0]  ex_ALUOp_s;
  logic [31:0] ex_pc_s, ex_rdata1_s, ex_rdata2_s, ex_imm_s;
  logic [4:0]  ex_rs1_s, ex_rs2_s, ex_rd_s;
  logic [3:0]  ex_funct_s;
  logic [3:0]  stall_count_s;

  exp_t m;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [7:0] ops [5];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_Branch(id_c[7]), .id_MemRead(id_c[6]), .id_MemtoReg(id_c[5]), .id_MemWrite(id_c[4]),
    .id_ALUSrc(id_c[3]), .id_RegWrite(id_c[2]), .id_ALUOp(id_c[1:0]),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
    .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .stall_count(stall_count)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_Branch(id_c[7]), .id_MemRead(id_c[6]), .id_MemtoReg(id_c[5]), .id_MemWrite(id_c[4]),
    .id_ALUSrc(id_c[3]), .id_RegWrite(id_c[2]), .id_ALUOp(id_c[1:0]),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold), .stall(stall_s), .ex_valid(ex_valid_s),
    .ex_Branch(ex_Branch_s), .ex_MemRead(ex_MemRead_s), .ex_MemtoReg(ex_MemtoReg_s),
    .ex_MemWrite(ex_MemWrite_s), .ex_ALUSrc(ex_ALUSrc_s), .ex_RegWrite(ex_RegWrite_s),
    .ex_ALUOp(ex_ALUOp_s), .ex_pc(ex_pc_s), .ex_rdata1(ex_rdata1_s), .ex_rdata2(ex_rdata2_s),
    .ex_imm(ex_imm_s), .ex_rs1(ex_rs1_s), .ex_rs2(ex_rs2_s), .ex_rd(ex_rd_s),
    .ex_funct(ex_funct_s), .stall_count(stall_count_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm);
    id_valid  = v;
    id_c      = c;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_rdata1 = d1;
    id_rdata2 = d2;
    id_imm    = imm;
    id_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
    id_funct  = 4'($urandom_range(0, 15));
  endtask

  task automatic compare(input exp_t e);
    check("ex_valid", 64'(ex_valid), 64'(e.valid));
    check("ex_ctrl", 64'({ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
                          ex_RegWrite, ex_ALUOp}), 64'(e.c));
    check("stall_count", 64'(stall_count), 64'(e.cnt));
    check("stall_count_sat", 64'(stall_count_s), 64'(e.cnt4));
    check("ex_valid_sat", 64'(ex_valid_s), 64'(e.valid));
    if (e.cmp) begin
      check("ex_pc", 64'(ex_pc), 64'(e.pc));
      check("ex_rdata1", 64'(ex_rdata1), 64'(e.d1));
      check("ex_rdata2", 64'(ex_rdata2), 64'(e.d2));
      check("ex_imm", 64'(ex_imm), 64'(e.imm));
      check("ex_rs", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({e.rs1, e.rs2, e.rd}));
      check("ex_funct", 64'(ex_funct), 64'(e.funct));
    end
  endtask

  // One clock: check stall for current inputs, predict next EX state, compare after edge
  task automatic cycle();
    exp_t n;
    logic hz, es;
    #1;
    hz = id_valid && m.valid && m.c[6] && (m.rd != 5'd0) &&
         ((m.rd == id_rs1) || ((!id_c[3] || id_c[4]) && (m.rd == id_rs2)));
    es = !reset && ((hz && !flush) || hold);
    check("stall", 64'(stall), 64'(es));
    check("stall_sat", 64'(stall_s), 64'(es));
    n = m;
    if (reset) begin
      n = '0;
      n.cmp = 1'b1;
    end else if (flush) begin
      n.valid = 1'b0;
      n.c = 8'd0;
      n.cmp = 1'b0;
    end else if (!hold) begin
      if (hz) begin
        n.valid = 1'b0;
        n.c = 8'd0;
        n.cmp = 1'b0;
        if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
        if (n.cnt4 != 4'hF) n.cnt4 = n.cnt4 + 4'd1;
      end else begin
        n.valid = id_valid;
        n.c = id_valid ? id_c : 8'd0;
        n.pc = id_pc; n.d1 = id_rdata1; n.d2 = id_rdata2; n.imm = id_imm;
        n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.funct = id_funct;
        n.cmp = 1'b1;
      end
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
    else compare(sb.pop_front());
  endtask

  initial begin
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_ADDI; ops[4] = OP_BEQ;
    m = '0;
    flush = 1'b0;
    hold  = 1'b1;
    reset = 1'b1;
    // reset with everything nonzero, hold raised too
    drive(1'b1, 8'hFF, 5'd1, 5'd2, 5'd3, 32'hAAAA_5555, 32'h1234_5678, 32'hFFFF_FFF0);
    cycle();
    cycle();
    hold  = 1'b0;
    reset = 1'b0;
    // R-type add x5, x6, x7
    drive(1'b1, OP_R, 5'd6, 5'd7, 5'd5, 32'h10, 32'h20, 32'h0);
    cycle();
    // lw x5 then add x8,x5,x9: one bubble, then add loads
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_R, 5'd5, 5'd9, 5'd8, 32'h1, 32'h2, 32'h0);
    cycle();
    cycle();
    // lw x5 then addi x8,x6,8 with rs2 field = 5: no hazard
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_ADDI, 5'd6, 5'd5, 5'd8, 32'h3, 32'h4, 32'h8);
    cycle();
    // lw x5 then sw x5,0(x6): rs2 is a source, hazard
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_SW, 5'd6, 5'd5, 5'd0, 32'h3, 32'h4, 32'h0);
    cycle();
    cycle();
    // hazard coinciding with flush: no stall, no count
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_R, 5'd5, 5'd9, 5'd8, 32'h1, 32'h2, 32'h0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    // lw x0 followed by a user of x0
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_R, 5'd0, 5'd0, 5'd8, 32'h1, 32'h2, 32'h0);
    cycle();
    // hold for 3 cycles with changing ID contents
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 5'(i + 10), 5'(i + 11), 5'(i + 12), $urandom, $urandom, $urandom);
      cycle();
    end
    hold = 1'b0;
    cycle();
    // hold with hazard pending, then release
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_BEQ, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 32'h10);
    hold = 1'b1;
    cycle();
    hold = 1'b0;
    cycle();
    cycle();
    // invalid ID slot with nonzero controls
    drive(1'b0, OP_LW, 5'd3, 5'd4, 5'd5, 32'h7, 32'h8, 32'h9);
    cycle();
    // reset while a hazard is pending drops the bubble
    drive(1'b1, OP_LW, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8);
    cycle();
    drive(1'b1, OP_R, 5'd5, 5'd9, 5'd8, 32'h1, 32'h2, 32'h0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    // lw x5,0(x5) chained: alternating bubbles drive the 4-bit counter to saturation
    drive(1'b1, OP_LW, 5'd5, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4);
    for (int i = 0; i < 40; i++) cycle();
    // random mix with occasional flush/hold/reset
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 7) != 0), ops[$urandom_range(0, 4)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
